// File: rtl/mem_map_pkg.sv
// mem_map_pkg: address map constants, region type and controller FSM state type
// shared by the memory-map controller and its address decoder.
package mem_map_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] REG_BASE    = 32'h0001_0000;
    localparam logic [31:0] STATUS_ADDR = 32'h0002_0000;

    // STATUS word bit positions
    localparam int STAT_BTN_BIT   = 0;
    localparam int STAT_PRESS_BIT = 1;
    localparam int STAT_ERR_BIT   = 2;

    typedef enum logic [1:0] {
        RAM,
        REG,
        STATUS,
        NONE
    } region_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

endpackage

// File: rtl/mem_map_decode.sv
// mem_map_decode: purely combinational byte-address to region decoder with a
// word-alignment flag and the scratch-register index.
module mem_map_decode
    import mem_map_pkg::*;
#(
    parameter int RAM_DEPTH = 1024,
    parameter int NUM_REGS  = 4
) (
    input  logic [31:0] addr,
    output region_t     region,
    output logic        aligned,
    output logic [3:0]  reg_idx
);

    // Region lookup; offsets use unsigned wrap so addresses below a base miss
    always_comb begin
        region = NONE;
        if ((addr - RAM_BASE) < 32'(RAM_DEPTH * 4)) begin
            region = RAM;
        end else if ((addr - REG_BASE) < 32'(NUM_REGS * 4)) begin
            region = REG;
        end else if (addr == STATUS_ADDR) begin
            region = STATUS;
        end
    end

    assign aligned = (addr[1:0] == 2'b00);
    assign reg_idx = addr[5:2];

endmodule

// File: rtl/mem_map_controller.sv
// mem_map_controller: single-outstanding request controller mapping a byte
// address space onto an external synchronous RAM, NUM_REGS scratch registers
// and a STATUS word (synchronised pushbutton, sticky press, sticky error).
// Build macro MEMCTRL_ERRSTAT_EN: when defined, misaligned/unmapped accesses
// answer with rsp_err=1 and set the sticky error bit; when undefined rsp_err is
// tied low and STATUS bit2 reads 0.
module mem_map_controller
    import mem_map_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int RD_LAT    = 1,
    parameter int NUM_REGS  = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_we,
    input  logic [31:0]                  req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    input  logic [DATA_W/8-1:0]          req_be,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    input  logic                         button,
    output logic [$clog2(RAM_DEPTH)-1:0] ram_addr,
    output logic [DATA_W-1:0]            ram_wdata,
    output logic [DATA_W/8-1:0]          ram_we,
    input  logic [DATA_W-1:0]            ram_rdata
);

    localparam int BE_W = DATA_W / 8;
    localparam int AW   = $clog2(RAM_DEPTH);

    state_t            state, state_nxt;
    logic [1:0]        cnt;
    region_t           region;
    logic              aligned;
    logic [3:0]        reg_idx;
    logic              accept, hit_err, ram_wr, ram_rd, reg_wr, stat_rd;
    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [DATA_W-1:0] rsp_data_nxt, status_word;
    logic              btn_p0, btn_p1, btn_p2, press_flag, err_bit;

    function automatic logic [DATA_W-1:0] be_merge(input logic [DATA_W-1:0] old_w,
                                                   input logic [DATA_W-1:0] new_w,
                                                   input logic [BE_W-1:0]   be);
        be_merge = old_w;
        for (int b = 0; b < BE_W; b++) begin
            if (be[b]) be_merge[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    mem_map_decode #(
        .RAM_DEPTH (RAM_DEPTH),
        .NUM_REGS  (NUM_REGS)
    ) u_decode (
        .addr    (req_addr),
        .region  (region),
        .aligned (aligned),
        .reg_idx (reg_idx)
    );

    // Ready is held low for as long as reset is asserted
    assign req_ready = reset && (state == IDLE || state == RESP);
    assign rsp_valid = (state == RESP);

    // Classify the accepted request into the actions it triggers
    always_comb begin
        accept  = req_valid & req_ready;
        hit_err = ~aligned | (region == NONE);
        ram_wr  = accept & ~hit_err & (region == RAM) & req_we;
        ram_rd  = accept & ~hit_err & (region == RAM) & ~req_we;
        reg_wr  = accept & ~hit_err & (region == REG) & req_we;
        stat_rd = accept & ~hit_err & (region == STATUS) & ~req_we;
    end

    // RAM port is driven straight from the request in the accept cycle
    assign ram_addr  = req_addr[AW+1:2];
    assign ram_wdata = req_wdata;
    assign ram_we    = ram_wr ? req_be : '0;

    // STATUS word as seen by a read in the current cycle
    always_comb begin
        status_word                 = '0;
        status_word[STAT_BTN_BIT]   = btn_p1;
        status_word[STAT_PRESS_BIT] = press_flag;
        status_word[STAT_ERR_BIT]   = err_bit;
    end

    // Read data for responses that complete one cycle after accept
    always_comb begin
        rsp_data_nxt = '0;
        if (accept && !hit_err && !req_we) begin
            if (region == STATUS) begin
                rsp_data_nxt = status_word;
            end else if (region == REG) begin
                for (int i = 0; i < NUM_REGS; i++) begin
                    if (reg_idx == 4'(i)) rsp_data_nxt = regs[i];
                end
            end
        end
    end

    // Next-state logic: RAM reads wait out the RAM latency, all else answers next cycle
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, RESP: begin
                if (accept) state_nxt = ram_rd ? WAIT : RESP;
                else        state_nxt = IDLE;
            end
            WAIT: begin
                if (cnt == 2'd0) state_nxt = RESP;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Latency counter and registered response data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_rdata <= '0;
            cnt       <= '0;
        end else if (state == WAIT) begin
            if (cnt == 2'd0) rsp_rdata <= ram_rdata;
            else             cnt       <= cnt - 2'd1;
        end else begin
            rsp_rdata <= rsp_data_nxt;
            cnt       <= 2'(RD_LAT - 1);
        end
    end

    // Scratch registers with per-byte write enables
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (reg_wr) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_idx == 4'(i)) regs[i] <= be_merge(regs[i], req_wdata, req_be);
            end
        end
    end

    // Button synchroniser, edge history and sticky press (a new press beats the read-clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_p0     <= 1'b0;
            btn_p1     <= 1'b0;
            btn_p2     <= 1'b0;
            press_flag <= 1'b0;
        end else begin
            btn_p0     <= button;
            btn_p1     <= btn_p0;
            btn_p2     <= btn_p1;
            press_flag <= (btn_p1 & ~btn_p2) | (press_flag & ~stat_rd);
        end
    end

`ifdef MEMCTRL_ERRSTAT_EN
    logic err_q, err_flag;

    // Error response flag and sticky error (a new error beats the read-clear)
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q    <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            err_q    <= accept & hit_err;
            err_flag <= (accept & hit_err) | (err_flag & ~stat_rd);
        end
    end

    assign rsp_err = err_q;
    assign err_bit = err_flag;
`else
    assign rsp_err = 1'b0;
    assign err_bit = 1'b0;
`endif

endmodule

// File: tb/tb_mem_map_controller.sv
// tb_mem_map_controller: directed and randomized checks of mem_map_controller
// against a behavioural model of the address map, with an external RAM model.
`timescale 1ns/1ps
module tb_mem_map_controller;

    localparam int DATA_W    = 32;
    localparam int RAM_DEPTH = 64;
    localparam int RD_LAT    = 2;
    localparam int NUM_REGS  = 4;
    localparam int AW        = $clog2(RAM_DEPTH);
`ifdef MEMCTRL_ERRSTAT_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [31:0]   req_addr = '0;
    logic [31:0]   req_wdata = '0;
    logic [3:0]    req_be = '0;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic          button = 1'b0;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_we;
    logic [31:0]   ram_rdata;

    int checks = 0;
    int errors = 0;

    // external RAM and its read pipeline
    logic [31:0] ram_mem [RAM_DEPTH] = '{default: '0};
    logic [31:0] rd_pipe [RD_LAT]    = '{default: '0};

    // reference model state
    logic [31:0] ref_ram  [RAM_DEPTH] = '{default: '0};
    logic [31:0] ref_regs [NUM_REGS]  = '{default: '0};
    bit m_press = 1'b0;
    bit m_err   = 1'b0;
    bit m_btn   = 1'b0;

    always #5 clk = ~clk;

    mem_map_controller #(
        .DATA_W    (DATA_W),
        .RAM_DEPTH (RAM_DEPTH),
        .RD_LAT    (RD_LAT),
        .NUM_REGS  (NUM_REGS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .button    (button),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_we    (ram_we),
        .ram_rdata (ram_rdata)
    );

    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (ram_we[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        rd_pipe[0] <= ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ram_rdata = rd_pipe[RD_LAT-1];

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                          input logic [3:0] be);
        merge = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merge[8*b +: 8] = new_w[8*b +: 8];
        end
    endfunction

    // Predict one access from the address-map rules and update the model state
    task automatic model(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, output logic [31:0] d, output logic e,
                         output int lat, output logic [3:0] exp_we);
        d = '0; e = 1'b0; lat = 1; exp_we = '0;
        if (addr[1:0] != 2'b00) begin
            e = ERR_EN;
            if (ERR_EN) m_err = 1'b1;
        end else if (addr < RAM_DEPTH * 4) begin
            if (we) begin
                exp_we = be;
                ref_ram[addr / 4] = merge(ref_ram[addr / 4], wdata, be);
            end else begin
                d   = ref_ram[addr / 4];
                lat = RD_LAT + 1;
            end
        end else if (addr >= 32'h1_0000 && addr < 32'h1_0000 + 4 * NUM_REGS) begin
            if (we) ref_regs[(addr - 32'h1_0000) / 4] = merge(ref_regs[(addr - 32'h1_0000) / 4], wdata, be);
            else    d = ref_regs[(addr - 32'h1_0000) / 4];
        end else if (addr == 32'h2_0000) begin
            if (!we) begin
                d = {29'b0, ERR_EN & m_err, m_press, m_btn};
                m_press = 1'b0;
                m_err   = 1'b0;
            end
        end else begin
            e = ERR_EN;
            if (ERR_EN) m_err = 1'b1;
        end
    endtask

    // Issue one request from idle and check strobe, latency and response
    task automatic txn(input string tag, input bit we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] got_d, output logic got_e, output int got_lat);
        logic [31:0] ed;
        logic        ee;
        int          el;
        logic [3:0]  ewe;
        int          lat;
        model(we, addr, wdata, be, ed, ee, el, ewe);
        @(negedge clk);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        #1;
        check({tag, "/ready"}, 32'(req_ready), 32'd1);
        check({tag, "/ram_we"}, 32'(ram_we), 32'(ewe));
        @(negedge clk);
        req_valid = 1'b0;
        lat = 1;
        while (rsp_valid !== 1'b1 && lat < 12) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "/latency"}, 32'(lat), 32'(el));
        check({tag, "/rdata"}, rsp_rdata, ed);
        check({tag, "/err"}, 32'(rsp_err), 32'(ee));
        got_d = rsp_rdata; got_e = rsp_err; got_lat = lat;
    endtask

    initial begin
        logic [31:0] gd, e0, e1, ed, a, w0, w1;
        logic        ge, ee;
        logic [3:0]  ewe;
        int          gl, el, first, second, sel;

        // reset state
        #1;
        check("rst/ready", 32'(req_ready), 32'd0);
        check("rst/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst/rsp_rdata", rsp_rdata, 32'd0);
        check("rst/rsp_err", 32'(rsp_err), 32'd0);
        check("rst/ram_we", 32'(ram_we), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst/ready_after", 32'(req_ready), 32'd1);
        for (int i = 0; i < NUM_REGS; i++) txn("rst/reg", 1'b0, 32'h1_0000 + 32'(4 * i), '0, '0, gd, ge, gl);

        // RAM write then read with RD_LAT=2
        txn("ram_wr", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'b1111, gd, ge, gl);
        check("ram_wr/latency_lit", 32'(gl), 32'd1);
        txn("ram_rd", 1'b0, 32'h10, '0, '0, gd, ge, gl);
        check("ram_rd/latency_lit", 32'(gl), 32'd3);
        check("ram_rd/rdata_lit", gd, 32'hDEAD_BEEF);

        // REG byte-enable merge
        txn("reg1_wr", 1'b1, 32'h1_0004, 32'h1122_3344, 4'b1111, gd, ge, gl);
        txn("reg1_be", 1'b1, 32'h1_0004, 32'hAABB_CCDD, 4'b0101, gd, ge, gl);
        txn("reg1_rd", 1'b0, 32'h1_0004, '0, '0, gd, ge, gl);
        check("reg1_rd/lit", gd, 32'h11BB_33DD);

        // button pulse, sticky press and read-clear
        txn("stat_clr", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        @(negedge clk); button = 1'b1; m_press = 1'b1;
        repeat (4) @(negedge clk);
        button = 1'b0;
        repeat (5) @(negedge clk);
        txn("stat_press", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        check("stat_press/lit", gd, 32'h2);
        txn("stat_reread", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        check("stat_reread/lit", gd, 32'h0);

        // button held: synchronised level visible, press cleared once read
        @(negedge clk); button = 1'b1; m_press = 1'b1;
        repeat (4) @(negedge clk);
        m_btn = 1'b1;
        txn("stat_held", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        check("stat_held/lit", gd, 32'h3);
        txn("stat_held2", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        check("stat_held2/lit", gd, 32'h1);
        @(negedge clk); button = 1'b0;
        repeat (4) @(negedge clk);
        m_btn = 1'b0;

        // unmapped read and sticky error
        txn("unmapped", 1'b0, 32'h3_0000, '0, '0, gd, ge, gl);
        check("unmapped/err_lit", 32'(ge), 32'(ERR_EN));
        check("unmapped/rdata_lit", gd, 32'h0);
        txn("stat_err", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);
        check("stat_err/lit", gd, {29'b0, ERR_EN, 2'b00});
        txn("ram_top", 1'b1, 32'(RAM_DEPTH * 4 - 4), 32'h5A5A_A5A5, 4'b1111, gd, ge, gl);
        txn("ram_past", 1'b1, 32'(RAM_DEPTH * 4), 32'h1234_5678, 4'b1111, gd, ge, gl);
        txn("reg_past", 1'b0, 32'h1_0000 + 32'(4 * NUM_REGS), '0, '0, gd, ge, gl);
        txn("misalign_wr", 1'b1, 32'h1_0005, 32'hFFFF_FFFF, 4'b1111, gd, ge, gl);

        // back-to-back reads with req_valid held
        w0 = $urandom; w1 = $urandom;
        txn("b2b_w0", 1'b1, 32'h0, w0, 4'b1111, gd, ge, gl);
        txn("b2b_w1", 1'b1, 32'h4, w1, 4'b1111, gd, ge, gl);
        model(1'b0, 32'h0, '0, '0, e0, ee, el, ewe);
        model(1'b0, 32'h4, '0, '0, e1, ee, el, ewe);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0; req_be = '0;
        first = 0; second = 0;
        for (int k = 1; k <= 20 && second == 0; k++) begin
            @(negedge clk);
            if (k == 1) req_addr = 32'h4;
            if (first != 0 && k == first + 1) req_valid = 1'b0;
            if (rsp_valid === 1'b1) begin
                if (first == 0) begin
                    first = k;
                    check("b2b/rdata0", rsp_rdata, e0);
                    check("b2b/ready_in_resp", 32'(req_ready), 32'd1);
                end else begin
                    second = k;
                    check("b2b/rdata1", rsp_rdata, e1);
                end
            end
        end
        req_valid = 1'b0;
        check("b2b/first_cycle", 32'(first), 32'(RD_LAT + 1));
        check("b2b/second_cycle", 32'(second), 32'(2 * (RD_LAT + 1)));

        // randomized mix across all regions and boundaries
        for (int n = 0; n < 80; n++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: a = (n % 10 == 0) ? 32'(RAM_DEPTH * 4 - 4) : 32'($urandom_range(0, 15) * 4);
                2: a = 32'h1_0000 + 32'(4 * $urandom_range(0, NUM_REGS));
                3: a = 32'h2_0000;
                4: begin
                    case ($urandom_range(0, 3))
                        0: a = 32'(RAM_DEPTH * 4);
                        1: a = 32'h3_0000;
                        2: a = 32'h2_0004;
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
                default: a = (($urandom_range(0, 1) == 0) ? 32'h1_0000 : 32'h0)
                             + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(1, 3));
            endcase
            txn("rand", 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom), gd, ge, gl);
        end

        // reset asserted while a RAM read is waiting
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_be = '0;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_wait/in_wait", 32'(req_ready), 32'd0);
        reset = 1'b0;
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8; req_wdata = 32'hFFFF_FFFF; req_be = 4'hF;
        #1;
        check("rst_wait/ready", 32'(req_ready), 32'd0);
        check("rst_wait/rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_wait/rsp_rdata", rsp_rdata, 32'd0);
        check("rst_wait/rsp_err", 32'(rsp_err), 32'd0);
        check("rst_wait/ram_we", 32'(ram_we), 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("rst_wait/no_rsp", 32'(rsp_valid), 32'd0);
        end
        req_valid = 1'b0;
        reset = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) ref_regs[i] = '0;
        m_press = 1'b0; m_err = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("rst_wait/no_late_rsp", 32'(rsp_valid), 32'd0);
        end
        txn("post_rst_ram", 1'b0, 32'h10, '0, '0, gd, ge, gl);
        txn("post_rst_ram8", 1'b0, 32'h8, '0, '0, gd, ge, gl);
        txn("post_rst_reg1", 1'b0, 32'h1_0004, '0, '0, gd, ge, gl);
        check("post_rst_reg1/lit", gd, 32'h0);
        txn("post_rst_stat", 1'b0, 32'h2_0000, '0, '0, gd, ge, gl);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
